// File: rtl/msg_assembler_if.sv
// Byte stream in / assembled frame out bus for msg_assembler.
// master drives received bytes and observes results; slave is the assembler.
interface msg_assembler_if;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [167:0] msg;
    logic         msg_valid;
    logic         frame_err;
    logic [15:0]  err_count;

    modport master (
        output rx_data, rx_valid,
        input  msg, msg_valid, frame_err, err_count
    );

    modport slave (
        input  rx_data, rx_valid,
        output msg, msg_valid, frame_err, err_count
    );
endinterface

// File: rtl/msg_assembler.sv
// Assembles 21-byte sync-framed messages from a byte stream, with idle timeout.
// Define MSG_CHECKSUM_EN to require byte 20 == XOR of bytes 0-19.
module msg_assembler #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input logic            clk,
    input logic            rst,
    msg_assembler_if.slave bus
);

    localparam logic [4:0]  LAST_IDX   = 5'd20;
    localparam int unsigned IDLE_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        IDLE_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic {
        HUNT,
        COLLECT
    } state_e;

    state_e            state_q, state_d;
    logic [4:0]        idx_q, idx_d;
    logic [IDLE_W-1:0] idle_q, idle_d;
    logic [167:0]      msg_q, msg_d;
    logic              msg_valid_q, msg_valid_d;
    logic              frame_err_q, frame_err_d;
    logic [15:0]       err_count_q, err_count_d;
    logic [159:0]      frame_q;
    logic              wr_en;
    logic              good_frame;
`ifdef MSG_CHECKSUM_EN
    logic [7:0]        csum_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            idle_q      <= '0;
            msg_q       <= '0;
            msg_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            idle_q      <= idle_d;
            msg_q       <= msg_d;
            msg_valid_q <= msg_valid_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    // NOTE: the partial-frame buffer has no reset; bytes 0-19 are always rewritten
    // before a frame can complete, so resetting it would only cost reset fanout.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < int'(LAST_IDX); i++) begin
                if (idx_q == 5'(i)) frame_q[8*i +: 8] <= bus.rx_data;
            end
        end
    end

`ifdef MSG_CHECKSUM_EN
    // Running XOR restarts on the sync byte, so it equals XOR(bytes 0..idx-1).
    always_ff @(posedge clk) begin
        if (wr_en) csum_q <= (idx_q == '0) ? bus.rx_data : (csum_q ^ bus.rx_data);
    end
`endif

    // NOTE: combinational next-state uses blocking assignments, and every output
    // gets a default first so no path leaves a variable unassigned (no latches).
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        idle_d      = idle_q;
        msg_d       = msg_q;
        msg_valid_d = 1'b0;
        frame_err_d = 1'b0;
        wr_en       = 1'b0;
`ifdef MSG_CHECKSUM_EN
        good_frame  = (bus.rx_data == csum_q);
`else
        good_frame  = 1'b1;
`endif

        case (state_q)
            HUNT: begin
                if (bus.rx_valid && bus.rx_data == SYNC_BYTE) begin
                    wr_en   = 1'b1;
                    idx_d   = 5'd1;
                    idle_d  = '0;
                    state_d = COLLECT;
                end
            end

            COLLECT: begin
                if (bus.rx_valid) begin
                    idle_d = '0;
                    if (idx_q == LAST_IDX) begin
                        state_d = HUNT;
                        idx_d   = '0;
                        if (good_frame) begin
                            msg_d       = {bus.rx_data, frame_q};
                            msg_valid_d = 1'b1;
                        end else begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 5'd1;
                    end
                end else if (TIMEOUT_EN) begin
                    // A byte in the would-be timeout cycle takes the branch above.
                    if (idle_q == IDLE_LAST) begin
                        state_d     = HUNT;
                        idx_d       = '0;
                        idle_d      = '0;
                        frame_err_d = 1'b1;
                    end else begin
                        idle_d = idle_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = HUNT;
                idx_d   = '0;
                idle_d  = '0;
            end
        endcase

        err_count_d = err_count_q;
        if (frame_err_d && err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
    end

    assign bus.msg       = msg_q;
    assign bus.msg_valid = msg_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.err_count = err_count_q;

    a_pulse_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(msg_valid_q && frame_err_q));

    a_index_range: assert property (@(posedge clk) disable iff (rst)
        idx_q <= LAST_IDX);

endmodule

// File: tb/tb_msg_assembler.sv
// Scoreboard bench for msg_assembler: stimulus pushes expected pulses, a monitor
// pops and compares them whenever msg_valid or frame_err is seen.
module tb_msg_assembler;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TMO  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    msg_assembler_if bus ();

    msg_assembler #(
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_msg;
        logic [167:0] msg;
        logic [15:0]  errc;
        int           cyc;
    } exp_t;

    exp_t         exp_q[$];
    int           cyc     = 0;
    int           checks  = 0;
    int           errors  = 0;
    logic [167:0] last_msg = '0;
    logic [15:0]  exp_err  = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [167:0] act, input logic [167:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [167:0] make_frame(input logic [31:0] seq,
                                                input logic [7:0] base,
                                                input logic [7:0] step);
        logic [167:0] f;
        logic [7:0]   cs;
        f        = '0;
        f[7:0]   = SYNC;
        f[39:8]  = seq;
        for (int k = 5; k < 20; k++) f[8*k +: 8] = base + 8'(step * k);
        cs = '0;
        for (int k = 0; k < 20; k++) cs = cs ^ f[8*k +: 8];
        f[167:160] = cs;
        return f;
    endfunction

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [167:0] f);
        for (int i = 0; i < 21; i++) send_byte(f[8*i +: 8]);
    endtask

    // Call right after the last byte was sampled: the pulse is due in this cycle.
    task automatic expect_msg(input logic [167:0] f);
        exp_t e;
        e.is_msg = 1'b1;
        e.msg    = f;
        e.errc   = exp_err;
        e.cyc    = cyc;
        exp_q.push_back(e);
        last_msg = f;
    endtask

    task automatic expect_err(input int at_cyc);
        exp_t e;
        if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
        e.is_msg = 1'b0;
        e.msg    = last_msg;
        e.errc   = exp_err;
        e.cyc    = at_cyc;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (bus.msg_valid || bus.frame_err)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got msg_valid=%0b frame_err=%0b at cycle %0d, expected none",
                         bus.msg_valid, bus.frame_err, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {bus.msg_valid, bus.frame_err}, e.is_msg ? 2'b10 : 2'b01);
                check("pulse_cycle", cyc, e.cyc);
                check("msg", bus.msg, e.msg);
                check("err_count", bus.err_count, e.errc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by 100000ns, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [167:0] f;
        logic [167:0] f2;

        bus.rx_data  = '0;
        bus.rx_valid = 1'b0;

        // Reset values while rst is held.
        #12;
        check("rst_msg", bus.msg, '0);
        check("rst_msg_valid", bus.msg_valid, '0);
        check("rst_frame_err", bus.frame_err, '0);
        check("rst_err_count", bus.err_count, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Seq 7, zero payload; checksum A5^07 = A2.
        f = {8'hA2, 120'h0, 32'h0000_0007, 8'hA5};
        send_frame(f);
        expect_msg(f);
        idle(2);

        // Leading junk bytes in HUNT are ignored.
        send_byte(8'h3C);
        send_byte(8'h11);
        f = make_frame(32'd3, 8'h10, 8'h03);
        send_frame(f);
        expect_msg(f);
        idle(1);

        // Payload made entirely of sync bytes is ordinary data.
        f = make_frame(32'd4, SYNC, 8'h00);
        send_frame(f);
        expect_msg(f);
        idle(1);

        // Back-to-back frames with rx_valid held for 42 cycles.
        f  = make_frame(32'd1, 8'h21, 8'h07);
        f2 = make_frame(32'd2, 8'h5A, 8'h11);
        send_frame(f);
        expect_msg(f);
        send_frame(f2);
        expect_msg(f2);
        idle(2);

        // Gaps of TMO-1 idle cycles: the byte arrives exactly at the timeout cycle.
        f = make_frame(32'd9, 8'h33, 8'h05);
        for (int i = 0; i < 21; i++) begin
            send_byte(f[8*i +: 8]);
            if (i == 0 || i == 10 || i == 19) idle(TMO - 1);
        end
        expect_msg(f);
        idle(2);

        // Ten bytes then TMO idle cycles: timeout discards the frame.
        f = make_frame(32'd10, 8'h44, 8'h02);
        for (int i = 0; i < 10; i++) send_byte(f[8*i +: 8]);
        expect_err(cyc + TMO);
        idle(TMO);
        idle(3);
        f = make_frame(32'd11, 8'h55, 8'h13);
        send_frame(f);
        expect_msg(f);
        idle(2);

        // Corrupted checksum byte.
        f = make_frame(32'd12, 8'h66, 8'h09);
        f[167:160] = f[167:160] ^ 8'h01;
        send_frame(f);
`ifdef MSG_CHECKSUM_EN
        expect_err(cyc);
`else
        expect_msg(f);
`endif
        idle(2);
        check("msg_hold", bus.msg, last_msg);

        // Asynchronous reset after byte 12 of a frame.
        f = make_frame(32'd13, 8'h77, 8'h0B);
        for (int i = 0; i < 13; i++) send_byte(f[8*i +: 8]);
        bus.rx_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_msg", bus.msg, '0);
        check("midrst_msg_valid", bus.msg_valid, '0);
        check("midrst_frame_err", bus.frame_err, '0);
        check("midrst_err_count", bus.err_count, '0);
        exp_err  = '0;
        last_msg = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        f = make_frame(32'd14, 8'h88, 8'h17);
        send_frame(f);
        expect_msg(f);
        idle(TMO + 3);

        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/msg_assembler.md
MSG_ASSEMBLER -- requirements
Module: msg_assembler

Interface
REQ-001 Parameter SYNC_BYTE, default 8'hA5, header value that opens a frame.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, max idle cycles between bytes inside a frame; 0 disables timeout.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 rx_data  input  8  received byte from serial front end.
REQ-006 rx_valid  input  1  rx_data valid this cycle; one byte accepted per cycle, no backpressure.
REQ-007 msg  output  168  last good assembled frame; feeds sequencer msg input.
REQ-008 msg_valid  output  1  one-cycle pulse, msg updated this cycle.
REQ-009 frame_err  output  1  one-cycle pulse on discarded frame (timeout or checksum).
REQ-010 err_count  output  16  discarded-frame count, saturating.

Function
REQ-011 Frame = 21 bytes; byte i lands in msg[8*i+7:8*i]; byte 0 = SYNC_BYTE, bytes 1-4 = sequence number little-endian (msg[39:8]), bytes 5-19 payload, byte 20 = checksum (msg[167:160]).
REQ-012 FSM states HUNT, COLLECT; reset state HUNT.
REQ-013 HUNT: byte accepted equal to SYNC_BYTE -> store as byte 0, byte index = 1, go COLLECT; other bytes ignored, no error.
REQ-014 COLLECT: each accepted byte stored at current index, index increments; byte with index 20 completes frame, return to HUNT.
REQ-015 Good completed frame: msg and msg_valid=1 registered the cycle after byte 20 is sampled (latency 1 cycle); msg otherwise holds value.
REQ-016 A byte accepted in the same cycle msg_valid is high is processed in HUNT (back-to-back frames, no gap cycle required).
REQ-017 Timeout: idle counter cleared on every accepted byte in COLLECT; reaching TIMEOUT_CYCLES without a byte -> discard partial frame, HUNT, frame_err pulse next cycle.
REQ-018 Byte arrival in the cycle the counter would hit TIMEOUT_CYCLES: byte wins, no timeout.
REQ-019 SYNC_BYTE value inside COLLECT is ordinary data, never restarts framing.
REQ-020 err_count increments by 1 per frame_err pulse, saturates at 16'hFFFF.
REQ-021 msg_valid and frame_err never high in the same cycle.

Reset
REQ-022 rst asserted: state HUNT, index 0, idle counter 0, msg = 0, msg_valid = 0, frame_err = 0, err_count = 0, immediately regardless of clk.
REQ-023 rst mid-frame: partial frame discarded, no frame_err, no err_count change.
REQ-024 First byte evaluated is the one sampled on the first rising edge with rst low.

Configuration
REQ-025 Macro MSG_CHECKSUM_EN defined: byte 20 must equal XOR of bytes 0-19; mismatch -> msg unchanged, no msg_valid, frame_err pulse, err_count +1.
REQ-026 MSG_CHECKSUM_EN undefined: byte 20 stored unchecked, every completed frame produces msg_valid; frame_err only from timeout.

Verification
REQ-027 Frame A5, seq 00000007 LE, payload 15x 00, correct XOR -> msg_valid 1 cycle after last byte, msg[39:8]=32'h7, msg[7:0]=8'hA5.
REQ-028 Bytes 3C, 11 then valid frame -> leading bytes ignored, one msg_valid, err_count 0.
REQ-029 Two valid frames back-to-back, rx_valid continuous 42 cycles -> two msg_valid pulses 21 cycles apart, seq 1 then 2.
REQ-030 TIMEOUT_CYCLES=8, 10 bytes then 8 idle cycles -> frame_err pulse, err_count=1, next valid frame accepted normally.
REQ-031 MSG_CHECKSUM_EN defined, byte 20 flipped -> no msg_valid, frame_err, err_count=1, msg holds prior value; undefined -> msg_valid.
REQ-032 rst pulse after byte 12 -> all outputs 0, subsequent full frame yields msg_valid, err_count 0.
